imem_loader: RTL
================

Name: imem_loader

Overview:
- Host-side writer for the IF-stage instruction-memory write port (i_wen / i_wdata).
- Accepts a byte stream from a debug/boot link, frames it into a little-endian program image, and emits 32-bit word writes with byte enables and a word address.
- Holds the core pipeline in reset until the image is fully and correctly loaded, then releases it.
- Sits between the boot link (UART/JTAG byte receiver) and the if_stage instruction memory.

Parameters:
DEPTH, 1024, instruction memory capacity in 32-bit words; images longer than this are rejected.
BASE_ADDR, 32'h0000_0000, byte address of the first written word.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
i_start  in  1  one-cycle pulse: begin a new load (also re-arms after DONE/ERR)
i_byte_valid  in  1  stream byte present
i_byte_data  in  8  stream byte
o_byte_ready  out  1  loader accepts the byte this cycle (transfer = valid & ready)
o_wen  out  4  instruction-memory byte enables (`IM_DATA_BYTES wide); 4'b1111 for one cycle per word
o_wdata  out  32  word to write
o_waddr  out  32  byte address of the word (BASE_ADDR + 4*index)
o_core_rst_n  out  1  active-low pipeline reset; 0 while loading, 1 only after successful load
o_done  out  1  level: image loaded
o_error  out  1  level: image rejected

Behaviour:
- Reset (async, immediate): state IDLE, o_byte_ready=0, o_wen=0, o_wdata=0, o_waddr=BASE_ADDR, o_core_rst_n=0, o_done=0, o_error=0, byte counter=0, word counter=0, length=0.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N words of 4 bytes each, LSB first, then the optional checksum byte.
- States: IDLE, LEN0, LEN1, DATA, CSUM (feature only), DONE, ERR.
- IDLE: ready=0. Stays here until i_start=1, then LEN0, clearing the counters, o_done and o_error, and driving o_core_rst_n=0.
- LEN0 / LEN1: ready=1; each accepted byte fills the length register, then advances one state.
- After LEN1:
  - N > DEPTH -> ERR.
  - N = 0 -> CSUM if the feature is compiled in, otherwise DONE.
  - Otherwise -> DATA.
- DATA: ready=1; a 2-bit byte index places each accepted byte into lane index of an assembly register.
  - On accepting lane 3, the next cycle drives o_wen=4'b1111, o_wdata=assembled word, o_waddr=BASE_ADDR+4*word_count.
  - The word counter increments after each write.
  - The write is registered and single-cycle; the next byte may be accepted in the same cycle (no bubble, ready stays 1).
- After word N-1 is accepted -> CSUM or DONE; the final write pulse still occurs one cycle later.
- DONE: ready=0, o_done=1. o_core_rst_n rises the cycle after the final o_wen pulse, never coincident with it.
- ERR: ready=0, o_error=1, o_core_rst_n=0, and no further writes.
- i_start in DONE or ERR: restart at LEN0 with o_core_rst_n=0 and o_done/o_error cleared.
- i_start in LEN0..CSUM: ignored.
- Bytes with i_byte_valid while ready=0 are not consumed.
- rst asserted mid-load aborts immediately to the reset values. Words already written stay in memory; the core remains held.
- Word counter and address never wrap, since N <= DEPTH is guaranteed before any write.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR accumulates all LEN and DATA bytes.
  - CSUM state (ready=1) accepts one byte. Equal to the accumulator -> DONE; otherwise -> ERR. Words already written stay in memory, but the core stays in reset.
- Undefined: no CSUM state, no accumulator; the frame ends after the last data byte.

Test Plan:
- Reset then i_start, stream 02 00 13 00 00 00 93 00 10 00 -> two writes:
  - addr 0x0, wdata 0x00000013;
  - addr 0x4, wdata 0x00100093;
  - o_wen=4'hF one cycle each, o_done=1, o_core_rst_n=1 one cycle after the 2nd write.
- i_start, stream length 01 04 (N=1025 > DEPTH=1024) -> ERR, o_error=1, zero o_wen pulses, o_byte_ready=0, o_core_rst_n stays 0.
- Length 00 00 (no checksum build) -> DONE without any write; o_core_rst_n=1.
- Back-to-back valid bytes every cycle for 4 words -> o_byte_ready never drops in DATA; 4 write pulses spaced exactly 4 cycles apart, addresses 0,4,8,C.
- rst pulsed after 6 data bytes -> all outputs at reset values asynchronously. A new i_start plus a full frame writes from address BASE_ADDR again.
- With IMEM_LOADER_CHECKSUM_EN, frame 01 00 13 00 00 00 followed by checksum:
  - checksum 0x12 -> DONE;
  - checksum 0x00 -> ERR, the word at 0x0 is still written, o_core_rst_n=0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-link byte stream to instruction-memory word writer; holds the core in reset until loaded.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic        o_byte_ready,
  output logic [3:0]  o_wen,
  output logic [31:0] o_wdata,
  output logic [31:0] o_waddr,
  output logic        o_core_rst_n,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_idx;
  logic [23:0] lanes;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  acc;
`endif

  logic        xfer;
  logic        restart;
  logic [15:0] n_len;

  assign xfer    = i_byte_valid & o_byte_ready;
  assign restart = i_start & ((state == IDLE) | (state == DONE) | (state == ERR));
  assign n_len   = {i_byte_data, len[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      len          <= '0;
      word_cnt     <= '0;
      byte_idx     <= '0;
      lanes        <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc          <= '0;
`endif
      o_byte_ready <= 1'b0;
      o_wen        <= '0;
      o_wdata      <= '0;
      o_waddr      <= BASE_ADDR;
      o_core_rst_n <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_wen <= '0;
      if (restart) begin
        state        <= LEN0;
        len          <= '0;
        word_cnt     <= '0;
        byte_idx     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        acc          <= '0;
`endif
        o_byte_ready <= 1'b1;
        o_core_rst_n <= 1'b0;
        o_done       <= 1'b0;
        o_error      <= 1'b0;
      end else begin
        case (state)
          LEN0: if (xfer) begin
            len[7:0] <= i_byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc      <= acc ^ i_byte_data;
`endif
            state    <= LEN1;
          end
          LEN1: if (xfer) begin
            len <= n_len;
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc <= acc ^ i_byte_data;
`endif
            if ({1'b0, n_len} > DEPTH_W) begin
              state        <= ERR;
              o_byte_ready <= 1'b0;
              o_error      <= 1'b1;
            end else if (n_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state        <= CSUM;
`else
              state        <= DONE;
              o_byte_ready <= 1'b0;
              o_done       <= 1'b1;
`endif
            end else begin
              state <= DATA;
            end
          end
          DATA: if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            acc      <= acc ^ i_byte_data;
`endif
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: lanes[7:0]   <= i_byte_data;
              2'd1: lanes[15:8]  <= i_byte_data;
              2'd2: lanes[23:16] <= i_byte_data;
              default: begin
                // Write is issued from the registered lanes plus the live top byte, so no bubble.
                o_wen    <= 4'b1111;
                o_wdata  <= {i_byte_data, lanes};
                o_waddr  <= BASE_ADDR + {14'd0, word_cnt, 2'b00};
                word_cnt <= word_cnt + 16'd1;
                if (word_cnt + 16'd1 == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state        <= CSUM;
`else
                  state        <= DONE;
                  o_byte_ready <= 1'b0;
                  o_done       <= 1'b1;
`endif
                end
              end
            endcase
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          CSUM: if (xfer) begin
            o_byte_ready <= 1'b0;
            if (i_byte_data == acc) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state   <= ERR;
              o_error <= 1'b1;
            end
          end
`endif
          // Release one cycle after entering DONE, i.e. after the final write pulse.
          DONE: o_core_rst_n <= 1'b1;
          ERR:  o_core_rst_n <= 1'b0;
          IDLE: o_byte_ready <= 1'b0;
          default: begin
            state        <= IDLE;
            o_byte_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
